// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: terminal-count modes and one-shot FSM states.
// Pure type definitions; no logic, no latency, no flow control.
package counter_pkg;

    typedef enum logic [1:0] {
        CM_WRAP    = 2'b00,
        CM_SAT     = 2'b01,
        CM_ONESHOT = 2'b10,
        CM_RSVD    = 2'b11
    } cnt_mode_e;

    typedef enum logic {
        CS_RUN  = 1'b0,
        CS_DONE = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/prog_counter_if.sv
// Control/status bundle of the programmable counter; the controller owns the master side.
// Plain wires, no latency; the counter never backpressures, so there is no handshake.
interface prog_counter_if
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] data;
    logic             enable;
    logic             up_dn;
    logic [WIDTH-1:0] limit;
    cnt_mode_e        mode;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;
    logic             done;

    modport master (
        output clear, load, data, enable, up_dn, limit, mode, ovf_clr,
        input  count, tc, ovf, done
    );

    modport slave (
        input  clear, load, data, enable, up_dn, limit, mode, ovf_clr,
        output count, tc, ovf, done
    );
endinterface

// File: rtl/prog_counter.sv
// Up/down modulo counter with wrap/saturate/one-shot terminal modes, tc pulse and sticky ovf.
// Count, tc, ovf and done update 1 cycle after the enabling edge; never stalls its controller.
module prog_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic           clk,
    input  logic           rst_,
    prog_counter_if.slave  bus
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    logic             r_ovf;
    logic             r_sat;
    cnt_state_e       r_state;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    logic             w_ovf_nxt;
    logic             w_sat_nxt;
    cnt_state_e       w_state_nxt;
    logic             w_term;

    // Up uses >= so a load beyond limit still terminates on the next step.
    assign w_term = bus.up_dn ? (r_cnt >= bus.limit) : (r_cnt == '0);

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf & ~bus.ovf_clr;
        w_sat_nxt   = 1'b0;
        w_state_nxt = (bus.mode == CM_ONESHOT) ? r_state : CS_RUN;

        if (bus.clear) begin
            w_cnt_nxt   = RST_VAL;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = CS_RUN;
        end else if (bus.load) begin
            w_cnt_nxt   = bus.data;
            w_state_nxt = CS_RUN;
        end else if (bus.enable) begin
            if (bus.mode == CM_ONESHOT && r_state == CS_DONE) begin
                w_cnt_nxt = r_cnt;
            end else if (!w_term) begin
                w_cnt_nxt = bus.up_dn ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
            end else begin
                case (bus.mode)
                    CM_SAT: begin
                        w_sat_nxt = 1'b1;
                        w_tc_nxt  = ~r_sat;
                        w_ovf_nxt = 1'b1;
                    end
                    CM_ONESHOT: begin
                        w_state_nxt = CS_DONE;
                        w_tc_nxt    = 1'b1;
                    end
                    default: begin
                        w_cnt_nxt = bus.up_dn ? '0 : bus.limit;
                        w_tc_nxt  = 1'b1;
                        w_ovf_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_cnt   <= RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_sat   <= 1'b0;
            r_state <= CS_RUN;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_sat   <= w_sat_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign bus.count = r_cnt;
    assign bus.tc    = r_tc;
    assign bus.ovf   = r_ovf;
    assign bus.done  = (r_state == CS_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Directed bench for prog_counter: stimulus pushes hand-computed per-cycle expectations,
// an independent monitor pops and compares them after every rising edge.
module tb_prog_counter;
    import counter_pkg::*;

    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic       ovf;
        logic       done;
    } exp_t;

    logic clk;
    logic rst_;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];
    string name_q[$];

    prog_counter_if #(.WIDTH(8)) bus ();

    prog_counter #(.WIDTH(8), .RST_VAL(8'd0)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Monitor: one expectation per cycle, compared just after the edge.
    initial begin
        exp_t e;
        exp_t a;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{cnt: bus.count, tc: bus.tc, ovf: bus.ovf, done: bus.done};
                n_checks++;
                if (a !== e) begin
                    n_errors++;
                    $display("FAIL %s: got cnt=%0d tc=%0b ovf=%0b done=%0b expected cnt=%0d tc=%0b ovf=%0b done=%0b",
                             nm, a.cnt, a.tc, a.ovf, a.done, e.cnt, e.tc, e.ovf, e.done);
                end
            end
        end
    end

    task automatic cyc(input logic clr, input logic ld, input logic en, input logic oc,
                       input logic [7:0] d, input logic [7:0] ec, input logic et,
                       input logic eo, input logic ed, input string nm);
        @(negedge clk);
        bus.clear   = clr;
        bus.load    = ld;
        bus.enable  = en;
        bus.ovf_clr = oc;
        bus.data    = d;
        exp_q.push_back('{cnt: ec, tc: et, ovf: eo, done: ed});
        name_q.push_back(nm);
    endtask

    task automatic cfg(input cnt_mode_e m, input logic ud, input logic [7:0] lim);
        @(negedge clk);
        bus.mode  = m;
        bus.up_dn = ud;
        bus.limit = lim;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_        = 1'b0;
        bus.clear   = 1'b0;
        bus.load    = 1'b0;
        bus.enable  = 1'b0;
        bus.ovf_clr = 1'b0;
        bus.data    = '0;
        bus.up_dn   = 1'b1;
        bus.limit   = 8'd5;
        bus.mode    = CM_WRAP;
        #12;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_tc",    32'(bus.tc),    32'd0);
        chk("rst_ovf",   32'(bus.ovf),   32'd0);
        chk("rst_done",  32'(bus.done),  32'd0);
        @(negedge clk);
        rst_ = 1'b1;

        // Wrap up to limit 5
        cfg(CM_WRAP, 1'b1, 8'd5);
        cyc(0,0,1,0, 8'd0, 8'd1, 0,0,0, "wrap_up_1");
        cyc(0,0,1,0, 8'd0, 8'd2, 0,0,0, "wrap_up_2");
        cyc(0,0,1,0, 8'd0, 8'd3, 0,0,0, "wrap_up_3");
        cyc(0,0,1,0, 8'd0, 8'd4, 0,0,0, "wrap_up_4");
        cyc(0,0,1,0, 8'd0, 8'd5, 0,0,0, "wrap_up_5");
        cyc(0,0,1,0, 8'd0, 8'd0, 1,1,0, "wrap_up_tc");
        cyc(0,0,0,0, 8'd0, 8'd0, 0,1,0, "wrap_up_hold");

        // Wrap down, reload from limit 9
        cfg(CM_WRAP, 1'b0, 8'd9);
        cyc(0,0,0,1, 8'd0, 8'd0, 0,0,0, "ovf_clr_1");
        cyc(0,1,0,0, 8'd2, 8'd2, 0,0,0, "dn_load");
        cyc(0,0,1,0, 8'd0, 8'd1, 0,0,0, "dn_1");
        cyc(0,0,1,0, 8'd0, 8'd0, 0,0,0, "dn_0");
        cyc(0,0,1,0, 8'd0, 8'd9, 1,1,0, "dn_wrap");
        cyc(0,0,1,0, 8'd0, 8'd8, 0,1,0, "dn_8");
        cyc(0,0,0,1, 8'd0, 8'd8, 0,0,0, "ovf_clr_2");

        // Saturate at 255: single tc pulse
        cfg(CM_SAT, 1'b1, 8'd255);
        cyc(0,1,0,0, 8'd253, 8'd253, 0,0,0, "sat_load");
        cyc(0,0,1,0, 8'd0, 8'd254, 0,0,0, "sat_1");
        cyc(0,0,1,0, 8'd0, 8'd255, 0,0,0, "sat_2");
        cyc(0,0,1,0, 8'd0, 8'd255, 1,1,0, "sat_3");
        cyc(0,0,1,0, 8'd0, 8'd255, 0,1,0, "sat_4");
        cyc(0,0,1,0, 8'd0, 8'd255, 0,1,0, "sat_5");

        // One-shot up to 3, mode-change release, load restart
        cfg(CM_ONESHOT, 1'b1, 8'd3);
        cyc(1,0,0,0, 8'd0, 8'd0, 0,0,0, "os_clear");
        cyc(0,0,1,0, 8'd0, 8'd1, 0,0,0, "os_1");
        cyc(0,0,1,0, 8'd0, 8'd2, 0,0,0, "os_2");
        cyc(0,0,1,0, 8'd0, 8'd3, 0,0,0, "os_3");
        cyc(0,0,1,0, 8'd0, 8'd3, 1,0,1, "os_done");
        cyc(0,0,1,0, 8'd0, 8'd3, 0,0,1, "os_ignore_1");
        cyc(0,0,1,0, 8'd0, 8'd3, 0,0,1, "os_ignore_2");
        bus.enable = 1'b0;
        cfg(CM_WRAP, 1'b1, 8'd3);
        cyc(0,0,0,0, 8'd0, 8'd3, 0,0,0, "os_mode_away");
        cfg(CM_ONESHOT, 1'b1, 8'd3);
        cyc(0,1,1,0, 8'd0, 8'd0, 0,0,0, "os_reload");
        cyc(0,0,1,0, 8'd0, 8'd1, 0,0,0, "os_resume");

        // limit 0 wrap: tc every step; then clear beats load beats enable
        cfg(CM_WRAP, 1'b1, 8'd0);
        cyc(0,0,1,0, 8'd0, 8'd0, 1,1,0, "lim0_a");
        cyc(0,0,1,0, 8'd0, 8'd0, 1,1,0, "lim0_b");
        cyc(1,1,1,0, 8'd7, 8'd0, 0,0,0, "clr_prio");
        cyc(0,1,1,0, 8'd7, 8'd7, 0,0,0, "load_prio");

        // Reach DONE at 42, then async reset mid-cycle
        cfg(CM_ONESHOT, 1'b1, 8'd42);
        cyc(0,1,0,0, 8'd40, 8'd40, 0,0,0, "ar_load");
        cyc(0,0,1,0, 8'd0, 8'd41, 0,0,0, "ar_41");
        cyc(0,0,1,0, 8'd0, 8'd42, 0,0,0, "ar_42");
        cyc(0,0,1,0, 8'd0, 8'd42, 1,0,1, "ar_done");
        @(negedge clk);
        bus.enable = 1'b0;
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("pre_ar_count", 32'(bus.count), 32'd42);
        chk("pre_ar_done",  32'(bus.done),  32'd1);
        rst_ = 1'b0;
        #1;
        chk("ar_count", 32'(bus.count), 32'd0);
        chk("ar_tc",    32'(bus.tc),    32'd0);
        chk("ar_ovf",   32'(bus.ovf),   32'd0);
        chk("ar_done_0", 32'(bus.done), 32'd0);
        @(negedge clk);
        rst_ = 1'b1;
        cyc(0,0,1,0, 8'd0, 8'd1, 0,0,0, "post_ar_step");
        @(posedge clk);
        #3;
        chk("queue_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
